fft_bitrev_reorder: RTL and testbench
=====================================

# fft_bitrev_reorder

Parametrised bit-reversal reorder engine for the FFT pipeline. It is the multi-lane successor of the two-port scramble stage. On a start pulse it streams FFT_SIZE words from a source region of dual/multi-port RAM, LANES words per cycle, and writes each word to its bit-reversed index in a destination region. Source base, destination base and mode (bit-reverse or straight copy) are latched per run. Busy/done handshake replaces free-running operation.

## Interface
- WORD_SIZE, 74, data word width (complex sample)
- ADDR_SIZE, 5, RAM address width
- FFT_SIZE, 16, points per run; power of 2, ≥ 2, ≤ 2^ADDR_SIZE
- LANES, 2, words per beat; power of 2, 1 ≤ LANES ≤ FFT_SIZE
- RD_LATENCY, 1, RAM read latency in cycles (≥ 1)

- i_CLK  in  1  clock, rising edge
- i_RST_N  in  1  asynchronous, active-low reset
- i_start  in  1  run request, sampled only in IDLE
- i_mode  in  1  0 = bit-reverse, 1 = straight copy
- i_src_base  in  ADDR_SIZE  source region base
- i_dst_base  in  ADDR_SIZE  destination region base
- i_rddata  in  LANES*WORD_SIZE  read data; lane k at bits [k*WORD_SIZE +: WORD_SIZE]
- o_busy  out  1  run in progress
- o_done  out  1  one-cycle completion pulse
- o_rden  out  1  read enable (all lanes)
- o_rdaddr  out  LANES*ADDR_SIZE  read addresses, lane k at [k*ADDR_SIZE +: ADDR_SIZE]
- o_wren  out  1  write enable (all lanes)
- o_wraddr  out  LANES*ADDR_SIZE  write addresses, same packing
- o_wrdata  out  LANES*WORD_SIZE  write data, same packing as i_rddata

## Operation
- Derived constants: BEATS = FFT_SIZE/LANES; FLIP = log2(FFT_SIZE).
- FSM states:
  - IDLE: i_start=1 latches i_src_base, i_dst_base and i_mode, clears the beat counter, and moves to READ.
  - READ: lasts exactly BEATS cycles. Beat b drives o_rden=1 and lane k reads src + b*LANES + k. After beat BEATS-1 the FSM moves to DRAIN.
  - DRAIN: lasts exactly RD_LATENCY cycles. o_rden=0; pending writes complete. Then the FSM moves to DONE.
  - DONE: lasts 1 cycle. o_done=1, then IDLE.
- Write index: i = b*LANES + k (FLIP bits).
  - Mode 0: lane k writes dst + bitrev_FLIP(i).
  - Mode 1: lane k writes dst + i.
- All address sums truncate to ADDR_SIZE bits (modulo wrap). No bounds error is raised.
- Write address and enable pass through a RD_LATENCY-deep register pipeline so they align with i_rddata.
- o_wrdata = i_rddata, combinational pass-through.
- Source and destination ranges that overlap give undefined results. The block does not check for this.
- o_busy = 1 in READ, DRAIN and DONE.
- i_start is ignored while o_busy=1, including the DONE cycle.
- Inputs i_src_base, i_dst_base and i_mode may change freely mid-run. Only the values latched at start are used.

## Timing
- Reset (async assert, sync-safe deassert): state = IDLE. o_busy, o_done, o_rden and o_wren are all 0. o_rdaddr and o_wraddr are 0. The write pipeline is cleared.
- Reset mid-run: outputs return to reset values immediately. No write is issued after reset deasserts until a new start is accepted.
- i_start is sampled high at edge T0:
  - o_busy rises after T0.
  - Beat b's o_rden/o_rdaddr are valid in cycle T0+1+b.
  - Beat b's o_wren/o_wraddr are valid in cycle T0+1+b+RD_LATENCY.
- Last write is in cycle T0+BEATS+RD_LATENCY.
- o_done is high in cycle T0+BEATS+RD_LATENCY+1. o_busy falls after it.
- Back-to-back runs: a start asserted in the first IDLE cycle after DONE is accepted. Run-to-run gap is 1 cycle.
- LANES = FFT_SIZE gives BEATS=1: a single read beat.
- o_wren is never high in IDLE.

## Test plan
- Basic bit-reverse (FFT_SIZE=8, LANES=2, RD_LATENCY=1, src=0, dst=8, mode 0), RAM[i]=i -> writes are {8,12}, {10,14}, {9,13}, {11,15} at T0+2..T0+5; o_done at T0+6; RAM[8..15] = 0,4,2,6,1,5,3,7.
- Copy mode, same config with mode 1 -> writes {8,9}, {10,11}, {12,13}, {14,15}; RAM[8..15] = 0..7.
- Wrap and latency (FFT_SIZE=8, LANES=4, RD_LATENCY=3, src=28, dst=4, ADDR_SIZE=5) -> beat 0 reads 28,29,30,31; beat 1 reads 0,1,2,3; first write at T0+4; o_done at T0+6.
- Start while busy plus back-to-back runs -> a start pulse mid-run causes no extra writes and no address change; a start in the first IDLE cycle after o_done begins the second run; both outputs are correct.
- Reset mid-run: assert i_RST_N=0 at T0+3 -> outputs go to 0 at once and no writes occur afterwards; a fresh run after release completes correctly.
- Base latching: change i_src_base and i_dst_base on the cycle after start -> addresses follow the original bases for the whole run.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversal reorder engine. Each run streams FFT_SIZE words from a source region, LANES
// words per beat, and writes each word to its bit-reversed index (or the same index) in a destination region.

module fft_bitrev_lane #(
   parameter int ADDR_SIZE = 5,
   parameter int FLIP      = 4,
   parameter int LANES     = 2,
   parameter int LANE      = 0,
   parameter int BW        = 1
) (
   input  logic [BW-1:0]        beat,
   input  logic [ADDR_SIZE-1:0] src,
   input  logic [ADDR_SIZE-1:0] dst,
   input  logic                 mode,
   output logic [ADDR_SIZE-1:0] rd_addr,
   output logic [ADDR_SIZE-1:0] wr_addr
);
   logic [FLIP-1:0] idx, rev;

   always_comb begin
      idx = FLIP'(32'(beat) * LANES + LANE);
      rev = '0;
      for (int j = 0; j < FLIP; j++) rev[j] = idx[FLIP-1-j];
   end

   assign rd_addr = src + ADDR_SIZE'(idx);
   assign wr_addr = dst + (mode ? ADDR_SIZE'(idx) : ADDR_SIZE'(rev));
endmodule

module fft_bitrev_reorder #(
   parameter int WORD_SIZE  = 74,
   parameter int ADDR_SIZE  = 5,
   parameter int FFT_SIZE   = 16,
   parameter int LANES      = 2,
   parameter int RD_LATENCY = 1
) (
   input  logic                       i_CLK,
   input  logic                       i_RST_N,
   input  logic                       i_start,
   input  logic                       i_mode,
   input  logic [ADDR_SIZE-1:0]       i_src_base,
   input  logic [ADDR_SIZE-1:0]       i_dst_base,
   input  logic [LANES*WORD_SIZE-1:0] i_rddata,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_rden,
   output logic [LANES*ADDR_SIZE-1:0] o_rdaddr,
   output logic                       o_wren,
   output logic [LANES*ADDR_SIZE-1:0] o_wraddr,
   output logic [LANES*WORD_SIZE-1:0] o_wrdata
);
   localparam int BEATS = FFT_SIZE / LANES;
   localparam int FLIP  = $clog2(FFT_SIZE);
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int DW    = $clog2(RD_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t                                      state;
   logic [BW-1:0]                               beat, n_beat;
   logic [ADDR_SIZE-1:0]                        src, dst, n_src, n_dst;
   logic                                        mode, n_mode;
   logic [DW-1:0]                               drain_cnt;
   logic                                        done_q, load, last_beat;
   logic [LANES-1:0][ADDR_SIZE-1:0]             rd_addr, wr_addr, rdaddr_q;
   logic [RD_LATENCY:0]                         vld_pipe;
   logic [RD_LATENCY:0][LANES-1:0][ADDR_SIZE-1:0] wa_pipe;

   // Lanes compute the addresses of the beat about to be issued, so the start cycle uses the live inputs
   assign last_beat = (beat == BW'(BEATS - 1));
   assign load      = (state == IDLE && i_start) || (state == READ && !last_beat);
   assign n_beat    = (state == IDLE) ? '0 : beat + 1'b1;
   assign n_src     = (state == IDLE) ? i_src_base : src;
   assign n_dst     = (state == IDLE) ? i_dst_base : dst;
   assign n_mode    = (state == IDLE) ? i_mode : mode;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      fft_bitrev_lane #(
         .ADDR_SIZE(ADDR_SIZE), .FLIP(FLIP), .LANES(LANES), .LANE(k), .BW(BW)
      ) u_lane (
         .beat(n_beat), .src(n_src), .dst(n_dst), .mode(n_mode),
         .rd_addr(rd_addr[k]), .wr_addr(wr_addr[k])
      );
   end

   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         state     <= IDLE;
         beat      <= '0;
         src       <= '0;
         dst       <= '0;
         mode      <= 1'b0;
         drain_cnt <= '0;
         done_q    <= 1'b0;
         rdaddr_q  <= '0;
         vld_pipe  <= '0;
         wa_pipe   <= '0;
      end else begin
         rdaddr_q <= load ? rd_addr : '0;
         // Write side trails the read by RD_LATENCY so it lines up with returning data
         vld_pipe <= {vld_pipe[RD_LATENCY-1:0], load};
         wa_pipe  <= {wa_pipe[RD_LATENCY-1:0], (load ? wr_addr : '0)};
         done_q   <= 1'b0;
         case (state)
            IDLE: if (i_start) begin
               src   <= i_src_base;
               dst   <= i_dst_base;
               mode  <= i_mode;
               beat  <= '0;
               state <= READ;
            end
            READ: if (last_beat) begin
               drain_cnt <= '0;
               state     <= DRAIN;
            end else begin
               beat <= beat + 1'b1;
            end
            DRAIN: if (drain_cnt == DW'(RD_LATENCY - 1)) begin
               done_q <= 1'b1;
               state  <= DONE;
            end else begin
               drain_cnt <= drain_cnt + 1'b1;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign o_busy   = (state != IDLE);
   assign o_done   = done_q;
   assign o_rden   = vld_pipe[0];
   assign o_rdaddr = rdaddr_q;
   assign o_wren   = vld_pipe[RD_LATENCY];
   assign o_wraddr = wa_pipe[RD_LATENCY];
   assign o_wrdata = i_rddata;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: a RAM model answers reads, and every read/write event is logged
// and compared with an event list built from the address rules and cycle timing.

module tb_fft_bitrev_reorder;
   localparam int WS = 16, AS = 5, N = 16, L = 4, RDL = 2;
   localparam int BEATS = N / L, FLIP = 4, RUN = BEATS + RDL + 1;

   typedef struct packed {
      logic          wr;
      logic [15:0]   cyc;
      logic [AS-1:0] addr;
      logic [WS-1:0] data;
   } ev_t;

   logic            clk = 0, rst_n = 0, start = 0, mode = 0;
   logic [AS-1:0]   src_base = '0, dst_base = '0;
   logic [L*WS-1:0] rddata = '0;
   logic            busy, done, rden, wren;
   logic [L*AS-1:0] rdaddr, wraddr;
   logic [L*WS-1:0] wrdata;

   fft_bitrev_reorder #(
      .WORD_SIZE(WS), .ADDR_SIZE(AS), .FFT_SIZE(N), .LANES(L), .RD_LATENCY(RDL)
   ) dut (
      .i_CLK(clk), .i_RST_N(rst_n), .i_start(start), .i_mode(mode),
      .i_src_base(src_base), .i_dst_base(dst_base), .i_rddata(rddata),
      .o_busy(busy), .o_done(done), .o_rden(rden), .o_rdaddr(rdaddr),
      .o_wren(wren), .o_wraddr(wraddr), .o_wrdata(wrdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [WS-1:0] mem [32];
   logic [WS-1:0] snap [32];
   logic [L*AS:0] rpipe [RDL+1] = '{default: '0};
   ev_t           log_q[$], exp_q[$];
   int            done_q[$];
   int            busy_cnt = 0, idle_wr = 0;
   int            checks = 0, failures = 0;

   function automatic ev_t mk(input logic w, input int c, input logic [AS-1:0] a, input logic [WS-1:0] d);
      mk = {w, 16'(c), a, d};
   endfunction

   // RAM model plus event monitor
   always @(negedge clk) begin
      for (int s = RDL; s > 0; s--) rpipe[s] = rpipe[s-1];
      rpipe[0] = {rden, rdaddr};
      for (int k = 0; k < L; k++)
         rddata[k*WS +: WS] = rpipe[RDL][L*AS] ? mem[rpipe[RDL][k*AS +: AS]] : '0;
      #1;
      if (rden) for (int k = 0; k < L; k++) log_q.push_back(mk(1'b0, cyc, rdaddr[k*AS +: AS], '0));
      if (wren) for (int k = 0; k < L; k++) begin
         mem[wraddr[k*AS +: AS]] = wrdata[k*WS +: WS];
         log_q.push_back(mk(1'b1, cyc, wraddr[k*AS +: AS], wrdata[k*WS +: WS]));
      end
      if (done) done_q.push_back(cyc);
      if (busy) busy_cnt++;
      if (wren && !busy) idle_wr++;
   end

   // Expected events of one run: read beat b in T0+1+b, its writes RDL cycles later
   function automatic void model(input int t0, input logic md, input logic [AS-1:0] s, input logic [AS-1:0] d);
      int i, r, x;
      for (int c = 1; c <= BEATS + RDL; c++) begin
         if (c <= BEATS)
            for (int k = 0; k < L; k++) exp_q.push_back(mk(1'b0, t0 + c, AS'(s + (c-1)*L + k), '0));
         if (c > RDL)
            for (int k = 0; k < L; k++) begin
               i = (c - 1 - RDL) * L + k;
               r = 0; x = i;
               for (int j = 0; j < FLIP; j++) begin r = r * 2 + x % 2; x = x / 2; end
               exp_q.push_back(mk(1'b1, t0 + c, AS'(d + (md ? i : r)), snap[AS'(s + i)]));
            end
      end
   endfunction

   task automatic fill_and_clear();
      for (int a = 0; a < 32; a++) begin mem[a] = WS'($urandom); snap[a] = mem[a]; end
      log_q.delete(); exp_q.delete(); done_q.delete();
      busy_cnt = 0; idle_wr = 0;
   endtask

   task automatic launch(input logic md, input logic [AS-1:0] s, input logic [AS-1:0] d, output int t0);
      @(posedge clk); #1;
      mode = md; src_base = s; dst_base = d; start = 1; t0 = cyc;
      @(posedge clk); #1;
      start = 0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, rden, wren, rdaddr, wraddr} !== '0) begin
         failures++; $display("FAIL reset_outputs got=%h exp=0", {busy, done, rden, wren, rdaddr, wraddr});
      end
      rst_n = 1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, rden, wren, rdaddr, wraddr} !== '0) begin
         failures++; $display("FAIL idle_outputs got=%h exp=0", {busy, done, rden, wren, rdaddr, wraddr});
      end
   endtask

   task automatic test_runs();
      logic [AS-1:0] srcs [7], dsts [7];
      logic          mds [7];
      int            t0;
      srcs = '{0, 16, 24, 4, 0, 0, 0};
      dsts = '{16, 0, 8, 20, 0, 0, 0};
      mds  = '{0, 1, 0, 1, 0, 0, 0};
      for (int n = 4; n < 7; n++) begin
         srcs[n] = AS'($urandom_range(0, 31));
         dsts[n] = srcs[n] + AS'(16);
         mds[n]  = 1'($urandom_range(0, 1));
      end
      for (int n = 0; n < 7; n++) begin
         fill_and_clear();
         launch(mds[n], srcs[n], dsts[n], t0);
         model(t0, mds[n], srcs[n], dsts[n]);
         repeat (RUN + 3) @(posedge clk);
         #1;
         checks++;
         if (log_q.size() != exp_q.size()) begin
            failures++; $display("FAIL run%0d events got=%0d exp=%0d", n, log_q.size(), exp_q.size());
         end else foreach (exp_q[i]) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin
               failures++; $display("FAIL run%0d ev%0d got=%h exp=%h", n, i, log_q[i], exp_q[i]); break;
            end
         end
         checks++;
         if (done_q.size() != 1 || done_q[0] != t0 + RUN) begin
            failures++; $display("FAIL run%0d done pulses=%0d exp one at %0d", n, done_q.size(), t0 + RUN);
         end
         checks++;
         if (busy_cnt != RUN || busy !== 1'b0 || idle_wr != 0) begin
            failures++; $display("FAIL run%0d busy cycles=%0d exp=%0d now=%b idle_wr=%0d", n, busy_cnt, RUN, busy, idle_wr);
         end
      end
   endtask

   task automatic test_base_latch();
      int t0;
      fill_and_clear();
      launch(1'b0, 5'd3, 5'd19, t0);
      src_base = 5'd12; dst_base = 5'd28; mode = 1'b1;
      model(t0, 1'b0, 5'd3, 5'd19);
      repeat (RUN + 3) @(posedge clk);
      #1;
      checks++;
      if (log_q.size() != exp_q.size()) begin
         failures++; $display("FAIL latch events got=%0d exp=%0d", log_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         checks++;
         if (log_q[i] !== exp_q[i]) begin
            failures++; $display("FAIL latch ev%0d got=%h exp=%h", i, log_q[i], exp_q[i]); break;
         end
      end
   endtask

   task automatic test_back_to_back();
      int t0;
      fill_and_clear();
      launch(1'b0, 5'd0, 5'd16, t0);
      for (int c = t0 + 2; c <= t0 + RUN + 2; c++) begin
         @(posedge clk); #1;
         if (c == t0 + 3) begin start = 1; src_base = 5'd9; dst_base = 5'd9; mode = 1'b1; end
         else if (c == t0 + 4) start = 0;
         else if (c == t0 + RUN) begin start = 1; src_base = 5'd0; dst_base = 5'd16; mode = 1'b1; end
         else if (c == t0 + RUN + 2) start = 0;
      end
      model(t0, 1'b0, 5'd0, 5'd16);
      model(t0 + RUN + 1, 1'b1, 5'd0, 5'd16);
      repeat (RUN + 3) @(posedge clk);
      #1;
      checks++;
      if (log_q.size() != exp_q.size()) begin
         failures++; $display("FAIL b2b events got=%0d exp=%0d", log_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         checks++;
         if (log_q[i] !== exp_q[i]) begin
            failures++; $display("FAIL b2b ev%0d got=%h exp=%h", i, log_q[i], exp_q[i]); break;
         end
      end
      checks++;
      if (done_q.size() != 2 || done_q[0] != t0 + RUN || done_q[1] != t0 + 2*RUN + 1) begin
         failures++; $display("FAIL b2b done pulses=%0d exp at %0d and %0d", done_q.size(), t0 + RUN, t0 + 2*RUN + 1);
      end
      checks++;
      if (busy_cnt != 2*RUN) begin
         failures++; $display("FAIL b2b busy cycles=%0d exp=%0d", busy_cnt, 2*RUN);
      end
   endtask

   task automatic test_reset_midrun();
      int t0;
      fill_and_clear();
      launch(1'b0, 5'd0, 5'd16, t0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 0;
      #1;
      checks++;
      if ({busy, done, rden, wren, rdaddr, wraddr} !== '0) begin
         failures++; $display("FAIL midrst_outputs got=%h exp=0", {busy, done, rden, wren, rdaddr, wraddr});
      end
      log_q.delete(); done_q.delete(); busy_cnt = 0;
      @(posedge clk); #1;
      rst_n = 1;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (log_q.size() != 0 || done_q.size() != 0 || busy_cnt != 0) begin
         failures++; $display("FAIL midrst_quiet events=%0d dones=%0d busy=%0d exp all 0", log_q.size(), done_q.size(), busy_cnt);
      end
      fill_and_clear();
      launch(1'b1, 5'd20, 5'd4, t0);
      model(t0, 1'b1, 5'd20, 5'd4);
      repeat (RUN + 3) @(posedge clk);
      #1;
      checks++;
      if (log_q.size() != exp_q.size() || done_q.size() != 1) begin
         failures++; $display("FAIL midrst_rerun events got=%0d exp=%0d dones=%0d", log_q.size(), exp_q.size(), done_q.size());
      end else foreach (exp_q[i]) begin
         checks++;
         if (log_q[i] !== exp_q[i]) begin
            failures++; $display("FAIL midrst_rerun ev%0d got=%h exp=%h", i, log_q[i], exp_q[i]); break;
         end
      end
   endtask

   initial begin
      for (int a = 0; a < 32; a++) mem[a] = '0;
      test_reset();
      test_runs();
      test_base_latch();
      test_back_to_back();
      test_reset_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
